// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Host-side loader for a processor memory-load port. It takes a little-endian
// byte stream made of a 4-byte word-count header (N) and N 32-bit words, and
// writes each assembled word into processor memory through memEn/memAddr/
// memData. The processor is held in reset for the whole load and is released
// RELEASE_DELAY cycles after the final write.
//
// Ports:
//   clock       in   rising-edge system clock
//   reset       in   asynchronous, active-high reset
//   load_start  in   single-cycle load request (ignored while busy)
//   byte_valid  in   byte source has a byte
//   byte_data   in   stream byte
//   byte_ready  out  loader accepts a byte (transfer on valid && ready)
//   memEn       out  memory write strobe (one cycle per word)
//   memAddr     out  word index being written (held when memEn=0)
//   memData     out  word being written (held when memEn=0)
//   cpu_reset   out  processor reset, active-high
//   busy        out  load in progress (header, payload or hold)
//   done        out  load finished and processor released
//   error       out  header rejected (N==0 or N>MEM_DEPTH)
//   state_dbg   out  current FSM state encoding, for observation only
//
// Byte handshake: a byte moves on a rising clock edge where byte_valid and
// byte_ready are both high; byte_ready does not depend on byte_valid, and a
// byte offered while byte_ready is low stays with the source.
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int WIDTH         = 32,
    parameter int MEM_DEPTH     = 1024,
    parameter int BASE_WORD     = 0,
    parameter int RELEASE_DELAY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             memEn,
    output logic [WIDTH-1:0] memAddr,
    output logic [WIDTH-1:0] memData,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       state_dbg
);

    localparam int KW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int HW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_HOLD  = 3'd4,
        S_RUN   = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       partial_q, partial_d;
    logic [KW-1:0]     k_q, k_d;
    logic [KW-1:0]     last_k_q, last_k_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic              mem_en_q, mem_en_d;
    logic [WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]  mem_data_q, mem_data_d;
    logic              byte_ready_q, byte_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_reset_q, cpu_reset_d;

    logic              accept;
    logic [31:0]       word_shift;

    // byte_ready_q is only ever high in HDR/DATA, so accept implies one of them.
    assign accept = byte_valid && byte_ready_q;

    // Little-endian assembly: earlier bytes already sit in partial_q[7:0]
    // upward, so the fourth byte lands in bits 31:24.
    assign word_shift = {byte_data, partial_q};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        partial_d  = partial_q;
        k_d        = k_q;
        last_k_d   = last_k_q;
        hold_cnt_d = hold_cnt_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (load_start) begin
                    state_d    = S_HDR;
                    byte_cnt_d = 2'd0;
                    partial_d  = '0;
                end
            end

            S_HDR: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    partial_d  = word_shift[31:8];
                    if (byte_cnt_q == 2'd3) begin
                        partial_d = '0;
                        if ((word_shift == 32'd0) || (word_shift > 32'(MEM_DEPTH))) begin
                            state_d = S_ERR;
                        end else begin
                            // Store N-1 so the last-word test is a plain compare
                            // and k never needs to reach MEM_DEPTH.
                            last_k_d = KW'(word_shift - 32'd1);
                            k_d      = '0;
                            state_d  = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    partial_d  = word_shift[31:8];
                    if (byte_cnt_q == 2'd3) begin
                        partial_d  = '0;
                        mem_addr_d = WIDTH'(BASE_WORD) + WIDTH'(k_q);
                        mem_data_d = WIDTH'(word_shift);
                        state_d    = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                if (k_q == last_k_q) begin
                    hold_cnt_d = HW'(RELEASE_DELAY - 1);
                    state_d    = S_HOLD;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = S_DATA;
                end
            end

            S_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered images of the next state, so they change on
        // the same edge as the state they describe.
        byte_ready_d = (state_d == S_HDR) || (state_d == S_DATA);
        mem_en_d     = (state_d == S_WRITE);
        busy_d       = (state_d == S_HDR) || (state_d == S_DATA) ||
                       (state_d == S_WRITE) || (state_d == S_HOLD);
        done_d       = (state_d == S_RUN);
        error_d      = (state_d == S_ERR);
        cpu_reset_d  = (state_d != S_RUN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            partial_q    <= '0;
            k_q          <= '0;
            last_k_q     <= '0;
            hold_cnt_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            partial_q    <= partial_d;
            k_q          <= k_d;
            last_k_q     <= last_k_d;
            hold_cnt_q   <= hold_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_reset_q  <= cpu_reset_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign memEn      = mem_en_q;
    assign memAddr    = mem_addr_q;
    assign memData    = mem_data_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clock;
  logic        reset;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        memEn;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  state_dbg;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_wr     = 0;
  int fall_cyc    = 0;
  int wr_count    = 0;
  logic prev_cpu_reset = 1'b1;

  logic [63:0] exp_q[$];

  program_loader dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .memEn      (memEn),
    .memAddr    (memAddr),
    .memData    (memData),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before 2000000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard / monitor, sampling on the falling edge
  always @(negedge clock) begin
    cyc++;
    if (memEn === 1'b1) begin
      wr_count++;
      last_wr = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_memEn", {memAddr, memData}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("mem_write", {memAddr, memData}, exp_q.pop_front());
      end
    end
    if (prev_cpu_reset && !cpu_reset) fall_cyc = cyc;
    prev_cpu_reset = cpu_reset;
  end

  // driver tasks (all driving happens at falling edges)
  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clock);
    byte_data  = b;
    byte_valid = 1'b1;
    w = 0;
    while (!byte_ready && w < 200) begin
      @(negedge clock);
      w++;
    end
    if (!byte_ready) check("byte_ready_timeout", {63'd0, byte_ready}, 64'd1);
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!done && w < 500) begin
      @(negedge clock);
      w++;
    end
    @(negedge clock);
    check("done", {63'd0, done}, 64'd1);
    check("busy_run", {63'd0, busy}, 64'd0);
    check("cpu_reset_run", {63'd0, cpu_reset}, 64'd0);
  endtask

  initial begin
    int wr_before;
    reset      = 1'b1;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #3;
    check("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    check("rst_memEn", {63'd0, memEn}, 64'd0);
    check("rst_byte_ready", {63'd0, byte_ready}, 64'd0);
    check("rst_outs", {busy, done, error, memAddr, memData}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // two-word load, no gaps
    pulse_start();
    check("busy_hdr", {63'd0, busy}, 64'd1);
    send_word(32'd2, 0);
    exp_q.push_back({32'd0, 32'h00A00513});
    send_word(32'h00A00513, 0);
    exp_q.push_back({32'd1, 32'h00000073});
    send_word(32'h00000073, 0);
    wait_done();
    check("release_delay", 64'(fall_cyc - last_wr), 64'd3);

    // same stream with gaps and a redundant load_start mid-payload
    wr_before = wr_count;
    pulse_start();
    send_word(32'd2, 5);
    exp_q.push_back({32'd0, 32'h00A00513});
    send_word(32'h00A00513, 5);
    exp_q.push_back({32'd1, 32'h00000073});
    send_byte(8'h73, 3);
    pulse_start();
    send_byte(8'h00, 2);
    send_byte(8'h00, 5);
    send_byte(8'h00, 0);
    wait_done();
    check("gapped_write_count", 64'(wr_count - wr_before), 64'd2);
    check("gapped_release", 64'(fall_cyc - last_wr), 64'd3);

    // N == 0 rejected, then recovery with N == 1
    pulse_start();
    send_word(32'd0, 0);
    repeat (4) @(negedge clock);
    check("err_zero", {63'd0, error}, 64'd1);
    check("err_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    check("err_busy", {busy, byte_ready}, 64'd0);
    pulse_start();
    check("err_cleared", {63'd0, error}, 64'd0);
    send_word(32'd1, 0);
    exp_q.push_back({32'd0, 32'hDEADBEEF});
    send_word(32'hDEADBEEF, 2);
    wait_done();
    check("recover_error", {63'd0, error}, 64'd0);

    // N == MEM_DEPTH+1 rejected, N == MEM_DEPTH accepted
    pulse_start();
    send_word(32'd1025, 0);
    repeat (2) @(negedge clock);
    check("err_over", {63'd0, error}, 64'd1);
    wr_before = wr_count;
    pulse_start();
    send_word(32'd1024, 0);
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] d;
      d = $urandom;
      exp_q.push_back({32'(i), d});
      send_word(d, 0);
    end
    wait_done();
    check("full_write_count", 64'(wr_count - wr_before), 64'd1024);

    // asynchronous reset after two bytes of the second word
    pulse_start();
    send_word(32'd2, 0);
    exp_q.push_back({32'd0, 32'h11223344});
    send_word(32'h11223344, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_byte_ready", {63'd0, byte_ready}, 64'd0);
    check("mid_rst_memEn", {63'd0, memEn}, 64'd0);
    check("mid_rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    check("mid_rst_flags", {61'd0, busy, done, error}, 64'd0);
    check("mid_rst_state", {61'd0, state_dbg}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    // a byte offered in IDLE must stay with the source
    byte_data  = 8'hFF;
    byte_valid = 1'b1;
    repeat (4) @(negedge clock);
    check("idle_no_ready", {63'd0, byte_ready}, 64'd0);
    byte_valid = 1'b0;
    pulse_start();
    send_word(32'd2, 1);
    exp_q.push_back({32'd0, 32'hCAFEF00D});
    send_word(32'hCAFEF00D, 1);
    exp_q.push_back({32'd1, 32'h0BADC0DE});
    send_word(32'h0BADC0DE, 1);
    wait_done();

    repeat (3) @(negedge clock);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
